// File: rtl/avalon_bus_arbiter.sv
// Two-master, one-slave round-robin arbiter for a 32-bit Avalon-style memory bus.
// Master 0 (CPU) and master 1 (loader/DMA) share one slave. Ownership is held for one complete
// transfer, then the arbiter drops to idle for one cycle before the next grant.
//
// Ports:
//   clk_i, reset_i          clock (rising edge), asynchronous active-high reset
//   m0_* / m1_*             master-side address/read/write/writedata/byteenable inputs,
//                           readdata/waitrequest outputs
//   s_*                     slave-side address/read/write/writedata/byteenable outputs,
//                           readdata/waitrequest inputs
//   grant_o                 one-hot current owner (01 = master 0, 10 = master 1, 00 = idle)
//   busy_o                  high while any master owns the slave
module avalon_bus_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                reset_i,

    input  logic [ADDR_W-1:0]   m0_address_i,
    input  logic                m0_read_i,
    input  logic                m0_write_i,
    input  logic [DATA_W-1:0]   m0_writedata_i,
    input  logic [DATA_W/8-1:0] m0_byteenable_i,
    output logic [DATA_W-1:0]   m0_readdata_o,
    output logic                m0_waitrequest_o,

    input  logic [ADDR_W-1:0]   m1_address_i,
    input  logic                m1_read_i,
    input  logic                m1_write_i,
    input  logic [DATA_W-1:0]   m1_writedata_i,
    input  logic [DATA_W/8-1:0] m1_byteenable_i,
    output logic [DATA_W-1:0]   m1_readdata_o,
    output logic                m1_waitrequest_o,

    output logic [ADDR_W-1:0]   s_address_o,
    output logic                s_read_o,
    output logic                s_write_o,
    output logic [DATA_W-1:0]   s_writedata_o,
    output logic [DATA_W/8-1:0] s_byteenable_o,
    input  logic [DATA_W-1:0]   s_readdata_i,
    input  logic                s_waitrequest_i,

    output logic [1:0]          grant_o,
    output logic                busy_o
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOwn0 = 2'd1,
        StOwn1 = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic       last_owner_q, last_owner_d;
    logic [1:0] grant_q;
    logic       busy_q;

    logic req0, req1;

    assign req0 = m0_read_i | m0_write_i;
    assign req1 = m1_read_i | m1_write_i;

    // Next-state: completion and abort both return to idle, which gives the mandatory bubble.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        case (state_q)
            StIdle: begin
                if (req0 && req1) begin
                    // Tie goes to whoever did not complete last; last_owner resets to 1.
                    state_d = last_owner_q ? StOwn0 : StOwn1;
                end else if (req0) begin
                    state_d = StOwn0;
                end else if (req1) begin
                    state_d = StOwn1;
                end
            end
            StOwn0: begin
                if (!req0) begin
                    state_d = StIdle;
                end else if (!s_waitrequest_i) begin
                    state_d      = StIdle;
                    last_owner_d = 1'b0;
                end
            end
            StOwn1: begin
                if (!req1) begin
                    state_d = StIdle;
                end else if (!s_waitrequest_i) begin
                    state_d      = StIdle;
                    last_owner_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Grant and busy are registered alongside the state so they track it exactly.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            last_owner_q <= 1'b1;
            grant_q      <= 2'b00;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            grant_q      <= {state_d == StOwn1, state_d == StOwn0};
            busy_q       <= (state_d != StIdle);
        end
    end

    // Slave side mirrors the owner combinationally; a non-owner that requests is stalled.
    always_comb begin
        s_address_o      = '0;
        s_read_o         = 1'b0;
        s_write_o        = 1'b0;
        s_writedata_o    = '0;
        s_byteenable_o   = '0;
        m0_waitrequest_o = req0;
        m1_waitrequest_o = req1;
        case (state_q)
            StOwn0: begin
                s_address_o      = m0_address_i;
                s_read_o         = m0_read_i;
                s_write_o        = m0_write_i;
                s_writedata_o    = m0_writedata_i;
                s_byteenable_o   = m0_byteenable_i;
                m0_waitrequest_o = s_waitrequest_i;
            end
            StOwn1: begin
                s_address_o      = m1_address_i;
                s_read_o         = m1_read_i;
                s_write_o        = m1_write_i;
                s_writedata_o    = m1_writedata_i;
                s_byteenable_o   = m1_byteenable_i;
                m1_waitrequest_o = s_waitrequest_i;
            end
            default: ;
        endcase
    end

    assign m0_readdata_o = s_readdata_i;
    assign m1_readdata_o = s_readdata_i;
    assign grant_o       = grant_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Bench for avalon_bus_arbiter: directed scenarios followed by random traffic, all checked
// every cycle against a transaction-level model of ownership, fairness and memory contents.
module tb_avalon_bus_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 4;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;

    logic [AW-1:0] m_addr [2];
    logic          m_rd   [2];
    logic          m_wr   [2];
    logic [DW-1:0] m_wd   [2];
    logic [BW-1:0] m_be   [2];
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          m0_wait, m1_wait;

    logic [AW-1:0] s_addr;
    logic          s_rd, s_wr;
    logic [DW-1:0] s_wd;
    logic [BW-1:0] s_be;
    logic [DW-1:0] s_rdata;
    logic          s_wait;
    logic [1:0]    grant;
    logic          busy;

    // Slave RAM (driven by what the DUT actually presents)
    logic [DW-1:0] ram [16];
    logic          ld_en;
    logic [3:0]    ld_idx;
    logic [DW-1:0] ld_val;

    // Reference model
    logic [DW-1:0] mdl_mem [16];
    int            owner;        // -1 none, else master index
    int            last;         // last master that completed
    logic          pend  [2];
    logic          t_wr  [2];
    logic [AW-1:0] t_addr[2];
    logic [DW-1:0] t_wd  [2];
    logic [BW-1:0] t_be  [2];

    // Observations of the DUT
    logic [1:0]    gseq [$];
    logic [1:0]    prev_g;
    logic [DW-1:0] rd_cap [2];
    int            w_cnt [2];
    int            streak [2];
    int            max_streak [2];
    int            stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    avalon_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .m0_address_i     (m_addr[0]),
        .m0_read_i        (m_rd[0]),
        .m0_write_i       (m_wr[0]),
        .m0_writedata_i   (m_wd[0]),
        .m0_byteenable_i  (m_be[0]),
        .m0_readdata_o    (m0_rdata),
        .m0_waitrequest_o (m0_wait),
        .m1_address_i     (m_addr[1]),
        .m1_read_i        (m_rd[1]),
        .m1_write_i       (m_wr[1]),
        .m1_writedata_i   (m_wd[1]),
        .m1_byteenable_i  (m_be[1]),
        .m1_readdata_o    (m1_rdata),
        .m1_waitrequest_o (m1_wait),
        .s_address_o      (s_addr),
        .s_read_o         (s_rd),
        .s_write_o        (s_wr),
        .s_writedata_o    (s_wd),
        .s_byteenable_o   (s_be),
        .s_readdata_i     (s_rdata),
        .s_waitrequest_i  (s_wait),
        .grant_o          (grant),
        .busy_o           (busy)
    );

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    assign s_rdata = ram[s_addr[5:2]];

    always @(posedge clk) begin
        if (ld_en) ram[ld_idx] <= ld_val;
        else if (s_wr && !s_wait) ram[s_addr[5:2]] <= merge(ram[s_addr[5:2]], s_wd, s_be);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_tx(input int i, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [BW-1:0] be);
        pend[i] = 1'b1; t_wr[i] = wr; t_addr[i] = a; t_wd[i] = d; t_be[i] = be;
    endtask

    task automatic drive();
        for (int i = 0; i < 2; i++) begin
            m_rd[i]   = pend[i] && !t_wr[i];
            m_wr[i]   = pend[i] && t_wr[i];
            m_addr[i] = t_addr[i];
            m_wd[i]   = t_wd[i];
            m_be[i]   = t_be[i];
        end
    endtask

    // One bus cycle: drive, check against the model, observe, advance the model, clock.
    task automatic cycle();
        logic [1:0]    eg;
        logic          eb, ers, ews;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [BW-1:0] ee;
        logic          ew [2];
        logic          wt [2];
        int            x;
        drive();
        #1;
        x = owner;
        eg = 2'b00; eb = 1'b0; ers = 1'b0; ews = 1'b0; ea = '0; ed = '0; ee = '0;
        ew[0] = pend[0]; ew[1] = pend[1];
        if (x >= 0) begin
            eg = (x == 0) ? 2'b01 : 2'b10;
            eb = 1'b1; ers = m_rd[x]; ews = m_wr[x];
            ea = m_addr[x]; ed = m_wd[x]; ee = m_be[x];
            ew[x] = s_wait;
        end
        check("grant", grant, eg);
        check("busy", busy, eb);
        check("s_read", s_rd, ers);
        check("s_write", s_wr, ews);
        check("s_address", s_addr, ea);
        check("s_writedata", s_wd, ed);
        check("s_byteenable", s_be, ee);
        check("m0_waitrequest", m0_wait, ew[0]);
        check("m1_waitrequest", m1_wait, ew[1]);
        if (x >= 0 && pend[x] && !t_wr[x] && !s_wait) begin
            check("m0_readdata", m0_rdata, mdl_mem[t_addr[x][5:2]]);
            check("m1_readdata", m1_rdata, mdl_mem[t_addr[x][5:2]]);
            rd_cap[x] = (x == 0) ? m0_rdata : m1_rdata;
        end
        if (grant != 2'b00 && prev_g == 2'b00) gseq.push_back(grant);
        prev_g = grant;
        wt[0] = m0_wait; wt[1] = m1_wait;
        for (int i = 0; i < 2; i++) begin
            if (wt[i]) w_cnt[i]++;
            streak[i] = wt[i] ? streak[i] + 1 : 0;
            if (streak[i] > max_streak[i]) max_streak[i] = streak[i];
        end
        if (m1_wait && grant == 2'b10) stall_cnt++;
        // Model: idle arbitrates, owner leaves on abort or completion.
        if (x < 0) begin
            if (pend[0] && pend[1]) owner = (last == 1) ? 0 : 1;
            else if (pend[0])      owner = 0;
            else if (pend[1])      owner = 1;
        end else if (!pend[x]) begin
            owner = -1;
        end else if (!s_wait) begin
            if (t_wr[x])
                mdl_mem[t_addr[x][5:2]] = merge(mdl_mem[t_addr[x][5:2]], t_wd[x], t_be[x]);
            pend[x] = 1'b0;
            owner   = -1;
            last    = x;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_idle(input int maxc);
        for (int k = 0; k < maxc && (pend[0] || pend[1]); k++) cycle();
    endtask

    // Raise reset mid-cycle and check that the slave side drops at once.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_grant", grant, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_s_read", s_rd, 1'b0);
        check("rst_s_write", s_wr, 1'b0);
        check("rst_s_address", s_addr, '0);
        owner = -1;
        last  = 1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic clear_obs();
        gseq.delete();
        prev_g = 2'b00;
        stall_cnt = 0;
        for (int i = 0; i < 2; i++) begin
            w_cnt[i] = 0; streak[i] = 0; max_streak[i] = 0;
        end
    endtask

    initial begin
        int            left [2];
        logic [1:0]    exp_g;
        logic [DW-1:0] v;

        for (int i = 0; i < 2; i++) begin
            pend[i] = 1'b0; t_wr[i] = 1'b0; t_addr[i] = '0; t_wd[i] = '0; t_be[i] = '0;
            rd_cap[i] = '0;
        end
        drive();
        s_wait = 1'b0;
        ld_en  = 1'b0; ld_idx = '0; ld_val = '0;
        owner  = -1; last = 1;
        clear_obs();

        // Preload RAM and model memory while reset is held.
        for (int i = 0; i < 16; i++) begin
            v = (i == 4) ? 32'hDEADBEEF : $urandom;
            ld_en = 1'b1; ld_idx = 4'(i); ld_val = v;
            mdl_mem[i] = v;
            @(posedge clk);
            #1;
        end
        ld_en = 1'b0;
        do_reset();

        // Solo read by master 0
        clear_obs();
        set_tx(0, 1'b0, 32'h0000_0010, '0, 4'hF);
        run_until_idle(20);
        cycle();
        check("solo_rd_grants", gseq.size(), 1);
        check("solo_rd_grant0", gseq[0], 2'b01);
        check("solo_rd_data", rd_cap[0], 32'hDEADBEEF);
        check("solo_rd_wait_cycles", w_cnt[0], 1);

        // Solo write by master 1, read back by master 0
        set_tx(1, 1'b1, 32'h0000_0020, 32'h12345678, 4'hF);
        run_until_idle(20);
        set_tx(0, 1'b0, 32'h0000_0020, '0, 4'hF);
        run_until_idle(20);
        check("wr_readback", rd_cap[0], 32'h12345678);

        // Tie right after reset: master 0 first, master 1 after one bubble
        do_reset();
        clear_obs();
        set_tx(0, 1'b0, 32'h4, '0, 4'hF);
        set_tx(1, 1'b0, 32'h8, '0, 4'hF);
        run_until_idle(20);
        check("tie_grants", gseq.size(), 2);
        check("tie_first", gseq[0], 2'b01);
        check("tie_second", gseq[1], 2'b10);
        check("tie_m1_wait_cycles", w_cnt[1], 3);

        // Continuous contention: 6 reads each, grants alternate
        clear_obs();
        left[0] = 6; left[1] = 6;
        for (int k = 0; k < 60 && (left[0] > 0 || left[1] > 0 || pend[0] || pend[1]); k++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && left[i] > 0) begin
                    set_tx(i, 1'b0, $urandom, '0, 4'hF);
                    left[i]--;
                end
            end
            cycle();
        end
        check("cont_grants", gseq.size(), 12);
        for (int k = 0; k < 12; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            check("cont_order", gseq[k], exp_g);
        end
        check("cont_fair0", max_streak[0] <= 3, 1'b1);
        check("cont_fair1", max_streak[1] <= 3, 1'b1);

        // Slave stall during a master 1 write with master 0 waiting
        clear_obs();
        set_tx(1, 1'b1, 32'h30, 32'hA5A55A5A, 4'b0110);
        cycle();
        set_tx(0, 1'b0, 32'h30, '0, 4'hF);
        s_wait = 1'b1;
        repeat (3) cycle();
        s_wait = 1'b0;
        cycle();
        run_until_idle(20);
        check("stall_m1_wait", stall_cnt, 3);
        check("stall_grants", gseq.size(), 2);
        check("stall_first", gseq[0], 2'b10);

        // Reset while master 0 owns the slave with a read in flight
        set_tx(0, 1'b0, 32'h40, '0, 4'hF);
        s_wait = 1'b1;
        cycle();
        check("mid_s_read_before", s_rd, 1'b1);
        set_tx(1, 1'b0, 32'h44, '0, 4'hF);
        drive();
        do_reset();
        pend[0] = 1'b0;
        s_wait  = 1'b0;
        clear_obs();
        cycle();
        cycle();
        check("mid_after_grants", gseq.size(), 1);
        check("mid_after_grant", gseq[0], 2'b10);
        run_until_idle(20);

        // Random traffic with stalls and occasional aborts
        for (int k = 0; k < 500; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1)
                    set_tx(i, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom));
                else if (pend[i] && $urandom_range(0, 39) == 0)
                    pend[i] = 1'b0;
            end
            s_wait = ($urandom_range(0, 2) == 0);
            cycle();
        end
        s_wait = 1'b0;
        run_until_idle(20);
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/avalon_bus_arbiter.md
Name: avalon_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the 32-bit Avalon-style memory bus.
- Lets the CPU (master 0) and a second bus master (master 1, e.g. a program loader or DMA) share one RAM slave.
- Sits between mips_cpu_bus and the RAM model, transparent to both.
- Round-robin arbitration; a grant is held for one complete transfer.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width; byteenable width is DATA_W/8

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- m0_address  in  ADDR_W  master 0 address
- m0_read  in  1  master 0 read request
- m0_write  in  1  master 0 write request
- m0_writedata  in  DATA_W  master 0 write data
- m0_byteenable  in  DATA_W/8  master 0 byte enables
- m0_readdata  out  DATA_W  read data to master 0
- m0_waitrequest  out  1  stall to master 0
- m1_* (address, read, write, writedata, byteenable, readdata, waitrequest): identical set for master 1
- s_address  out  ADDR_W  address to slave
- s_read  out  1  slave read strobe
- s_write  out  1  slave write strobe
- s_writedata  out  DATA_W  write data to slave
- s_byteenable  out  DATA_W/8  byte enables to slave
- s_readdata  in  DATA_W  slave read data
- s_waitrequest  in  1  slave stall
- grant  out  2  one-hot current owner; 00 when idle
- busy  out  1  high while any master owns the slave

Behaviour:
- Requesting: master m requests when m_read | m_write. Masters hold all request signals stable while their waitrequest is high.
- State machine: IDLE, OWN0, OWN1. State and last_owner are registered.
- Reset (async): state=IDLE, last_owner=1. Effects are immediate, not clock-gated: grant=00, busy=0, s_read=s_write=0, s_address/s_writedata/s_byteenable=0.
- IDLE:
  - Slave strobes are 0.
  - Every requesting master sees waitrequest=1; a non-requesting master sees 0.
  - On a clock edge with only m0 requesting, go to OWN0; only m1, go to OWN1.
  - With both requesting, grant the master that is not last_owner; on the first tie after reset, m0 wins.
- OWNx:
  - s_* outputs mirror master x combinationally.
  - mx_waitrequest = s_waitrequest. The other master's waitrequest = 1 if it is requesting, else 0.
  - grant = one-hot x, busy=1.
- Completion: a transfer completes on the edge where s_waitrequest=0 and s_read|s_write=1. Next state is IDLE and last_owner is set to x.
- Bubble: there is one mandatory IDLE cycle between transfers, so back-to-back accesses by one master are 2+ cycles apart.
- Abort: if master x drops both read and write while owning, the arbiter returns to IDLE on the next edge with no slave strobe. last_owner is unchanged.
- Read data: m0_readdata = m1_readdata = s_readdata, broadcast. Only the granted master may sample it.
- Simultaneous read and write from one master: forwarded unchanged, not checked.
- Latency: a request seen in IDLE reaches the slave on the next cycle. Zero-wait slave: 2 cycles from request to completion for an unopposed master.
- Fairness: under continuous contention, grants alternate 0,1,0,1… and neither master waits more than one other transfer.
- Reset mid-transfer: slave strobes drop in the same cycle reset rises. After reset deasserts, arbitration restarts from IDLE with m0 favoured.

Test Plan:
- Solo read: m0_read=1, m0_address=0x00000010, RAM holds 0xDEADBEEF at that address → grant=01 next cycle, s_read=1; on completion m0_waitrequest=0, m0_readdata=0xDEADBEEF, then grant=00.
- Solo write: m1_write=1, address 0x20, writedata 0x12345678, byteenable 0xF → s_write asserted one cycle later with identical values. A later m0 read of 0x20 returns 0x12345678.
- Tie after reset: m0 and m1 request in the same cycle → m0 served first with m1_waitrequest=1 throughout; m1 granted after one IDLE bubble.
- Continuous contention: both masters issue 6 reads each → grant sequence 01,10,01,10,01,10,… and no master waits more than one transfer plus bubble.
- Slave stall: RAM holds s_waitrequest=1 for 3 cycles during an m1 write → m1_waitrequest=1 for those 3 cycles; m0 request pending and stalled; grant stays 10 until completion.
- Reset mid-transfer: assert reset while OWN0 with s_read=1 → s_read=0, grant=00, busy=0 in the same cycle; after release, a pending m1 request is granted next edge.
